// File: rtl/param_fifo_if.sv
// param_fifo_if: bundles the FIFO request/data/status signals.
//   master modport: drives read/write/inputBus, observes data and status.
//   slave modport : the FIFO side, consumes requests and drives data and status.
//   read, write  : single-cycle pop/push request strobes
//   inputBus     : write data
//   outputBus    : read data
//   empty, full, almost_empty, almost_full, count : occupancy status
//   overflow, underflow : sticky error flags
interface param_fifo_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            read;
  logic            write;
  logic [WIDTH-1:0] inputBus;
  logic [WIDTH-1:0] outputBus;
  logic            empty;
  logic            full;
  logic            almost_empty;
  logic            almost_full;
  logic [CntW-1:0] count;
  logic            overflow;
  logic            underflow;

  modport master (
    output read, write, inputBus,
    input  outputBus, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  read, write, inputBus,
    output outputBus, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports:
//   clk   : single clock, all state updates on posedge
//   reset : synchronous, active-low; clears pointers, count, output and flags
//   bus   : param_fifo_if.slave (read/write/inputBus in, data and status out)
// Configuration macro PARAM_FIFO_FWFT_EN:
//   defined   -> first-word-fall-through, outputBus shows the head word combinationally
//   undefined -> registered read, outputBus loads the popped word at the popping edge
module param_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic         clk,
  input logic         reset,
  param_fifo_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfLvl   = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLvl   = CntW'(AE_LEVEL);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            pop_ok, push_ok;
  logic            empty;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign empty = (count_q == '0);

  always_comb begin
    pop_ok  = bus.read & ~empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    push_ok = bus.write & ((count_q != CntFull) | pop_ok);

    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (bus.write & ~push_ok);
    udf_d = udf_q | (bus.read & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; reset only discards it by rewinding the pointers.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= bus.inputBus;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign bus.outputBus = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Holds the last popped word, including across rejected pops.
  always_comb begin
    dout_d = dout_q;
    if (pop_ok) begin
      dout_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.outputBus = dout_q;
`endif

  assign bus.empty        = empty;
  assign bus.full         = (count_q == CntFull);
  assign bus.almost_empty = (count_q <= AeLvl);
  assign bus.almost_full  = (count_q >= AfLvl);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: a DEPTH=4 and a DEPTH=5 instance. Each stimulus cycle
// queues its hand-computed expectations; a monitor pops them after the clock edge and
// compares the selected instance's outputs.
module tb_param_fifo;

`ifdef PARAM_FIFO_FWFT_EN
  localparam bit Fwft = 1'b1;
`else
  localparam bit Fwft = 1'b0;
`endif

  typedef struct {
    bit         rst_n;
    bit         sel;      // 0: DEPTH=4 instance, 1: DEPTH=5 instance
    bit         rd;
    bit         wr;
    logic [7:0] din;
    bit         pop_exp;  // a word must leave the FIFO at this edge
    logic [7:0] pop_val;
    bit         out_chk;  // check outputBus right after this edge
    logic [7:0] out_val;
    int         cnt;
    bit         ovf;
    bit         udf;
  } vec_t;

  logic clk;
  logic rst_n;
  vec_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   ovf_e = 1'b0;
  bit   udf_e = 1'b0;
  logic [7:0] prev4, prev5;

  param_fifo_if #(.DEPTH(4), .WIDTH(8)) if4 ();
  param_fifo_if #(.DEPTH(5), .WIDTH(8)) if5 ();

  param_fifo #(.DEPTH(4), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if4)
  );

  param_fifo #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each queued expectation after the edge that applied it.
  always @(posedge clk) begin
    vec_t v;
    int   cnt_a, full_lvl, af_lvl;
    logic [7:0] out_a, prev_a;
    #1;
    if (q.size() > 0) begin
      v = q.pop_front();
      n_vec++;
      cnt_a    = v.sel ? int'(if5.count) : int'(if4.count);
      out_a    = v.sel ? if5.outputBus : if4.outputBus;
      prev_a   = v.sel ? prev5 : prev4;
      full_lvl = v.sel ? 5 : 4;
      af_lvl   = v.sel ? 4 : 3;
      chk("count", cnt_a, v.cnt);
      chk("empty", int'(v.sel ? if5.empty : if4.empty), int'(v.cnt == 0));
      chk("full", int'(v.sel ? if5.full : if4.full), int'(v.cnt == full_lvl));
      chk("almost_empty", int'(v.sel ? if5.almost_empty : if4.almost_empty), int'(v.cnt <= 1));
      chk("almost_full", int'(v.sel ? if5.almost_full : if4.almost_full),
          int'(v.cnt >= af_lvl));
      chk("overflow", int'(v.sel ? if5.overflow : if4.overflow), int'(v.ovf));
      chk("underflow", int'(v.sel ? if5.underflow : if4.underflow), int'(v.udf));
      // FWFT shows the popped word before the edge; registered mode after it.
      if (v.pop_exp) chk("pop_data", int'(Fwft ? prev_a : out_a), int'(v.pop_val));
      if (v.out_chk) chk("outputBus", int'(out_a), int'(v.out_val));
    end
    prev4 = if4.outputBus;
    prev5 = if5.outputBus;
  end

  task automatic apply(input bit r_n, input bit sel, input bit rd, input bit wr,
                       input logic [7:0] din, input bit pop_exp, input logic [7:0] pop_val,
                       input bit out_chk, input logic [7:0] out_val, input int cnt);
    vec_t v;
    @(negedge clk);
    rst_n        = r_n;
    if4.read     = !sel && rd;
    if4.write    = !sel && wr;
    if4.inputBus = din;
    if5.read     = sel && rd;
    if5.write    = sel && wr;
    if5.inputBus = din;
    v = '{rst_n: r_n, sel: sel, rd: rd, wr: wr, din: din, pop_exp: pop_exp,
          pop_val: pop_val, out_chk: out_chk, out_val: out_val, cnt: cnt,
          ovf: sel ? 1'b0 : ovf_e, udf: sel ? 1'b0 : udf_e};
    q.push_back(v);
  endtask

  task automatic psh(input bit sel, input logic [7:0] d, input int cnt);
    apply(1'b1, sel, 1'b0, 1'b1, d, 1'b0, 8'h00, 1'b0, 8'h00, cnt);
  endtask

  task automatic pop(input bit sel, input logic [7:0] d, input int cnt);
    apply(1'b1, sel, 1'b1, 1'b0, 8'h00, 1'b1, d, 1'b0, 8'h00, cnt);
  endtask

  task automatic rw(input bit sel, input logic [7:0] d, input logic [7:0] popv, input int cnt);
    apply(1'b1, sel, 1'b1, 1'b1, d, 1'b1, popv, 1'b0, 8'h00, cnt);
  endtask

  task automatic rst(input bit sel);
    ovf_e = 1'b0;
    udf_e = 1'b0;
    apply(1'b0, sel, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    if4.read     = 1'b0;
    if4.write    = 1'b0;
    if4.inputBus = 8'h00;
    if5.read     = 1'b0;
    if5.write    = 1'b0;
    if5.inputBus = 8'h00;

    // Reset held for two edges.
    rst(1'b0);
    rst(1'b1);

    // Fill, overflow, drain in order.
    psh(1'b0, 8'h0C, 1);
    psh(1'b0, 8'h09, 2);
    psh(1'b0, 8'h03, 3);
    psh(1'b0, 8'hA5, 4);
    ovf_e = 1'b1;
    psh(1'b0, 8'h77, 4);
    pop(1'b0, 8'h0C, 3);
    pop(1'b0, 8'h09, 2);
    pop(1'b0, 8'h03, 1);
    pop(1'b0, 8'hA5, 0);

    // Pop on empty: output holds (registered) or reads zero (FWFT).
    udf_e = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, Fwft ? 8'h00 : 8'hA5, 0);

    // Full with simultaneous read and write.
    psh(1'b0, 8'h0C, 1);
    psh(1'b0, 8'h09, 2);
    psh(1'b0, 8'h03, 3);
    psh(1'b0, 8'hA5, 4);
    rw(1'b0, 8'h5A, 8'h0C, 4);
    pop(1'b0, 8'h09, 3);
    pop(1'b0, 8'h03, 2);
    pop(1'b0, 8'hA5, 1);
    pop(1'b0, 8'h5A, 0);
    // Empty with simultaneous read and write: push only, no forwarding when registered.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, Fwft ? 8'h33 : 8'h5A, 1);
    pop(1'b0, 8'h33, 0);

    // Mid-operation reset discards stored data.
    psh(1'b0, 8'h11, 1);
    psh(1'b0, 8'h22, 2);
    psh(1'b0, 8'h33, 3);
    rst(1'b0);
    psh(1'b0, 8'h42, 1);
    pop(1'b0, 8'h42, 0);

    // DEPTH=5: interleaved traffic wrapping the pointers.
    psh(1'b1, 8'h01, 1);
    psh(1'b1, 8'h02, 2);
    for (int k = 3; k <= 12; k++) rw(1'b1, 8'(k), 8'(k - 2), 2);
    pop(1'b1, 8'h0B, 1);
    pop(1'b1, 8'h0C, 0);
    // DEPTH=5 fill to full and drain.
    for (int k = 1; k <= 5; k++) psh(1'b1, 8'(8'h20 + k), k);
    for (int k = 1; k <= 5; k++) pop(1'b1, 8'(8'h20 + k), 5 - k);

    @(negedge clk);
    if4.read  = 1'b0;
    if4.write = 1'b0;
    if5.read  = 1'b0;
    if5.write = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
